mini16_code_loader: RTL and testbench



---
 rtl/mini16_code_loader.sv | 131 +++++++++++++
 tb/tb_mini16_code_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mini16_code_loader.sv
// rtl/mini16_code_loader.sv - boot loader: byte stream to mini16 instruction memory, XOR-checked
// Holds the CPU in reset until a length-prefixed little-endian image with a good checksum has been written.
module mini16_code_loader #(
  parameter int WIDTH_I = 16,
  parameter int DEPTH_I = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  input  logic [7:0]         s_data,
  output logic               s_ready,
  input  logic               load_req,
  output logic               cpu_reset,
  output logic [DEPTH_I-1:0] mem_i_w_addr,
  output logic [WIDTH_I-1:0] mem_i_w_data,
  output logic               mem_i_we,
  output logic               done,
  output logic               error
);

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'(2 ** DEPTH_I);

  state_t      state;
  state_t      state_next;
  logic [15:0] count;
  logic [15:0] word_cnt;
  logic [7:0]  low_byte;
  logic [7:0]  csum;
  logic        accept;
  logic [15:0] len_full;
  logic        too_long;
  logic        last_word;
  logic        csum_ok;

  always_comb begin
    s_ready = 1'b0;
    case (state)
      S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CSUM: s_ready = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  always_comb begin
    accept     = s_valid & s_ready;
    len_full   = {s_data, count[7:0]};
    too_long   = {1'b0, len_full} > MAX_WORDS;
    last_word  = (word_cnt + 16'd1) == count;
    csum_ok    = s_data == csum;
    state_next = state;
    // load_req wins over a same-cycle accept; that byte is swallowed
    if (load_req) begin
      state_next = S_LEN_LO;
    end else if (accept) begin
      case (state)
        S_LEN_LO:  state_next = S_LEN_HI;
        S_LEN_HI: begin
          if (too_long)              state_next = S_ERR;
          else if (len_full == 16'd0) state_next = S_CSUM;
          else                        state_next = S_DATA_LO;
        end
        S_DATA_LO: state_next = S_DATA_HI;
        S_DATA_HI: state_next = last_word ? S_CSUM : S_DATA_LO;
        S_CSUM:    state_next = csum_ok ? S_RUN : S_ERR;
        default:   state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_LEN_LO;
      count        <= 16'd0;
      word_cnt     <= 16'd0;
      low_byte     <= 8'd0;
      csum         <= 8'd0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      mem_i_we     <= 1'b0;
      mem_i_w_addr <= '0;
      mem_i_w_data <= '0;
    end else begin
      state    <= state_next;
      mem_i_we <= 1'b0;
      if (load_req) begin
        count     <= 16'd0;
        word_cnt  <= 16'd0;
        csum      <= 8'd0;
        cpu_reset <= 1'b1;
        done      <= 1'b0;
        error     <= 1'b0;
      end else if (accept) begin
        if (state != S_CSUM) csum <= csum ^ s_data;
        case (state)
          S_LEN_LO:  count[7:0] <= s_data;
          S_LEN_HI: begin
            count[15:8] <= s_data;
            if (too_long) error <= 1'b1;
          end
          S_DATA_LO: low_byte <= s_data;
          S_DATA_HI: begin
            mem_i_we     <= 1'b1;
            mem_i_w_addr <= word_cnt[DEPTH_I-1:0];
            mem_i_w_data <= WIDTH_I'({s_data, low_byte});
            word_cnt     <= word_cnt + 16'd1;
          end
          S_CSUM: begin
            if (csum_ok) begin
              cpu_reset <= 1'b0;
              done      <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mini16_code_loader.sv
// tb/tb_mini16_code_loader.sv - self-checking bench for mini16_code_loader
// Streams are scored against a list-level model of the image format (word list, byte XOR, length limit).
module tb_mini16_code_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic       s_ready;
  logic       load_req = 1'b0;
  logic       cpu_reset;
  logic [7:0] mem_i_w_addr;
  logic [15:0] mem_i_w_data;
  logic       mem_i_we;
  logic       done;
  logic       error;

  mini16_code_loader #(.WIDTH_I(16), .DEPTH_I(8)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .load_req(load_req), .cpu_reset(cpu_reset), .mem_i_w_addr(mem_i_w_addr),
    .mem_i_w_data(mem_i_w_data), .mem_i_we(mem_i_we), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  wr_t        wq[$];
  int         acc_cyc[$];
  logic [7:0] stream[$];
  int         exp_words[$];
  int         exp_consumed;
  bit         exp_ok;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t w;
    if (mem_i_we === 1'b1) begin
      w.cyc  = cyc;
      w.addr = int'(mem_i_w_addr);
      w.data = int'(mem_i_w_data);
      wq.push_back(w);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: what the image format says should happen for the bytes in 'stream'
  task automatic model();
    int n;
    logic [7:0] x;
    exp_words.delete();
    n = int'(stream[0]) + 256 * int'(stream[1]);
    if (n > 256) begin
      exp_consumed = 2;
      exp_ok = 1'b0;
      return;
    end
    for (int k = 0; k < n; k++)
      exp_words.push_back(int'(stream[2+2*k]) + 256 * int'(stream[3+2*k]));
    x = 8'd0;
    for (int i = 0; i < 2 + 2 * n; i++) x = x ^ stream[i];
    exp_consumed = 3 + 2 * n;
    exp_ok = (stream[2+2*n] == x);
  endtask

  task automatic make_stream(input int n, input bit corrupt);
    logic [7:0] x;
    stream.delete();
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
    for (int i = 0; i < 2 * n; i++) stream.push_back(8'($urandom));
    x = 8'd0;
    foreach (stream[i]) x = x ^ stream[i];
    if (corrupt) x = x ^ 8'($urandom_range(255, 1));
    stream.push_back(x);
  endtask

  task automatic send_bytes(input int n, input int gap_max);
    for (int i = 0; i < n; i++) begin
      int idle;
      int waited;
      idle = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      waited = 0;
      repeat (idle) begin
        @(negedge clk);
        s_valid = 1'b0;
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = stream[i];
      while (s_ready !== 1'b1) begin
        waited++;
        if (waited > 50) begin
          n_checks++;
          n_fail++;
          $display("FAIL send_timeout: byte %0d s_ready=%b, required 1 within 50 cycles", i, s_ready);
          s_valid = 1'b0;
          return;
        end
        @(negedge clk);
      end
      acc_cyc.push_back(cyc);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic pulse_load_req();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Drive the whole expected-consumed part of 'stream' and score writes and final status
  task automatic drive_and_score(input string name, input int gap_max);
    model();
    wq.delete();
    acc_cyc.delete();
    send_bytes(exp_consumed, gap_max);
    n_checks++;
    if (wq.size() != exp_words.size()) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d, required %0d", name, wq.size(), exp_words.size());
    end
    for (int k = 0; k < wq.size() && k < exp_words.size(); k++) begin
      n_checks++;
      if (wq[k].addr != k || wq[k].data != exp_words[k] || wq[k].cyc != acc_cyc[3+2*k] + 1) begin
        n_fail++;
        $display("FAIL %s write[%0d]: got addr %0d data %h cyc %0d, required addr %0d data %h cyc %0d",
                 name, k, wq[k].addr, wq[k].data, wq[k].cyc, k, exp_words[k], acc_cyc[3+2*k] + 1);
      end
    end
    n_checks++;
    if ({done, error, cpu_reset, s_ready} !== {exp_ok, !exp_ok, !exp_ok, 1'b0}) begin
      n_fail++;
      $display("FAIL %s status: got done=%b error=%b cpu_reset=%b s_ready=%b, required %b %b %b 0",
               name, done, error, cpu_reset, s_ready, exp_ok, !exp_ok, !exp_ok);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({s_ready, cpu_reset, mem_i_we, done, error} !== 5'b11000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ready/cpu_reset/we/done/error=%b%b%b%b%b, required 11000",
               s_ready, cpu_reset, mem_i_we, done, error);
    end
    n_checks++;
    if (mem_i_w_addr !== 8'd0 || mem_i_w_data !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mem: got addr %h data %h, required 00 0000", mem_i_w_addr, mem_i_w_data);
    end
  endtask

  task automatic test_basic();
    stream = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A};
    drive_and_score("basic", 0);
    n_checks++;
    if (wq.size() != 2 || wq[0].data != 'h1234 || wq[1].data != 'h5678 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_literal: got %0d writes done=%b, required 1234,5678 done=1", wq.size(), done);
    end
    pulse_load_req();
  endtask

  task automatic test_bad_csum();
    stream = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0B};
    drive_and_score("bad_csum", 0);
    n_checks++;
    if (wq.size() != 2 || error !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_csum_literal: got %0d writes error=%b done=%b, required 2 1 0", wq.size(), error, done);
    end
    pulse_load_req();
    n_checks++;
    if (error !== 1'b0 || s_ready !== 1'b1 || cpu_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_csum_reload: got error=%b s_ready=%b cpu_reset=%b, required 0 1 1", error, s_ready, cpu_reset);
    end
  endtask

  task automatic test_len_bounds();
    stream = '{8'h00, 8'h00, 8'h00};
    drive_and_score("zero_len", 1);
    pulse_load_req();
    stream = '{8'h01, 8'h01, 8'h55};
    drive_and_score("too_long", 0);
    n_checks++;
    if (error !== 1'b1 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL too_long_literal: got error=%b s_ready=%b, required 1 0", error, s_ready);
    end
    pulse_load_req();
  endtask

  task automatic test_full_random_gaps();
    make_stream(256, 1'b0);
    drive_and_score("full_256", 3);
  endtask

  task automatic test_load_req();
    @(negedge clk);
    load_req = 1'b1;
    s_valid  = 1'b1;
    s_data   = 8'h03;
    @(negedge clk);
    load_req = 1'b0;
    s_valid  = 1'b0;
    n_checks++;
    if (cpu_reset !== 1'b1 || done !== 1'b0 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_req_run: got cpu_reset=%b done=%b s_ready=%b, required 1 0 1", cpu_reset, done, s_ready);
    end
    stream = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'h50};
    drive_and_score("beef", 0);
    n_checks++;
    if (wq.size() != 1 || wq[0].addr != 0 || wq[0].data != 'hBEEF) begin
      n_fail++;
      $display("FAIL beef_literal: got %0d writes, required one write 0xBEEF at 0", wq.size());
    end
    pulse_load_req();
    make_stream(4, 1'b0);
    send_bytes(5, 0);
    @(negedge clk);
    load_req = 1'b1;
    s_valid  = 1'b1;
    s_data   = 8'($urandom);
    @(negedge clk);
    load_req = 1'b0;
    s_valid  = 1'b0;
    make_stream(3, 1'b0);
    drive_and_score("abort_reload", 1);
    pulse_load_req();
  endtask

  task automatic test_reset_midload();
    make_stream(5, 1'b0);
    model();
    wq.delete();
    acc_cyc.delete();
    send_bytes(9, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({s_ready, cpu_reset, mem_i_we, done, error} !== 5'b11000 || mem_i_w_addr !== 8'd0 ||
        mem_i_w_data !== 16'd0) begin
      n_fail++;
      $display("FAIL midload_reset: got ready/cpu_reset/we/done/error=%b%b%b%b%b addr %h data %h, required 11000 00 0000",
               s_ready, cpu_reset, mem_i_we, done, error, mem_i_w_addr, mem_i_w_data);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (wq.size() != 3 || wq[2].addr != 2) begin
      n_fail++;
      $display("FAIL midload_writes: got %0d writes, required 3 (addr 0..2, none at 3)", wq.size());
    end
    make_stream(5, 1'b0);
    drive_and_score("after_reset", 2);
    pulse_load_req();
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      make_stream(int'($urandom_range(12, 0)), ($urandom_range(2, 0) == 0));
      drive_and_score("random", 2);
      pulse_load_req();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_len_bounds();
    test_full_random_gaps();
    test_load_req();
    test_reset_midload();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
